// File: rtl/rgmii_inband_status_ctrl_pkg.sv
// Shared types for the RGMII in-band status link controller: speed codes,
// link FSM states and the decoded {link, spd, dup} status word.
package rgmii_inband_status_ctrl_pkg;

  localparam logic [1:0] SPEED_10M  = 2'b00;
  localparam logic [1:0] SPEED_100M = 2'b01;
  localparam logic [1:0] SPEED_1G   = 2'b10;

  typedef enum logic [1:0] {
    ST_DOWN = 2'd0,
    ST_HOLD = 2'd1,
    ST_UP   = 2'd2
  } link_state_e;

  typedef struct packed {
    logic       link;
    logic [1:0] spd;
    logic       dup;
  } link_status_t;

  // Speed can be masked out when the speed is being forced externally.
  function automatic logic status_differs(link_status_t a, link_status_t b, logic ignore_spd);
    return (a.link != b.link) || (a.dup != b.dup) || (!ignore_spd && (a.spd != b.spd));
  endfunction

endpackage

// File: rtl/rgmii_inband_status_ctrl_if.sv
// Receive-bus / link-status bundle between the GMII receive datapath and the
// link controller.
interface rgmii_inband_status_ctrl_if;
  import rgmii_inband_status_ctrl_pkg::*;

  // No valid/ready handshake: the receive bus is sampled on every clk edge and
  // gmii_rx_dv/gmii_rx_er qualify it; the status outputs change only on commits.
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [1:0] speed;
  logic       link_up;
  logic       full_duplex;
  logic       mac_rst;
  logic       status_change;

  modport master (
    output gmii_rxd, gmii_rx_dv, gmii_rx_er,
    input  speed, link_up, full_duplex, mac_rst, status_change
  );

  modport slave (
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
    output speed, link_up, full_duplex, mac_rst, status_change
  );

endinterface

// File: rtl/inband_status_debounce.sv
// Qualifies in-band status samples between frames and debounces them; raises
// commit_o for one cycle when a stable candidate differs from the committed status.
module inband_status_debounce
  import rgmii_inband_status_ctrl_pkg::*;
#(
  parameter int STABLE_COUNT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rxd_i,
  input  logic         rx_dv_i,
  input  logic         rx_er_i,
  input  link_status_t committed_i,
  input  logic         ignore_spd_i,
  output logic         commit_o,
  output link_status_t cand_o
);

  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_COUNT);
  localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_COUNT - 1);

  link_status_t  sample;
  link_status_t  cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid;

  always_comb begin
    sample.link = rxd_i[0];
    sample.spd  = rxd_i[2:1];
    sample.dup  = rxd_i[3];
    // Frames, carrier extension, nibble mismatch and the reserved speed code
    // all freeze the debouncer rather than clearing it.
    valid = !rx_dv_i && !rx_er_i && (rxd_i[3:0] == rxd_i[7:4]) && (rxd_i[2:1] != 2'b11);
  end

  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    commit_o = 1'b0;
    if (valid) begin
      if (sample != cand_q) begin
        cand_d = sample;
        cnt_d  = CW'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d    = cnt_q + 1'b1;
        commit_o = (cnt_q == CNT_ARM) && status_differs(cand_q, committed_i, ignore_spd_i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cand_o = cand_q;

endmodule

// File: rtl/rgmii_inband_status_ctrl.sv
// RGMII in-band status link controller: drives speed/link/duplex from debounced
// in-band status and sequences mac_rst. Optional macro RGMII_INBAND_FORCE_EN adds force_en/force_speed.
module rgmii_inband_status_ctrl
  import rgmii_inband_status_ctrl_pkg::*;
#(
  parameter int         STABLE_COUNT  = 16,
  parameter int         RESET_HOLD    = 8,
  parameter logic [1:0] DEFAULT_SPEED = SPEED_1G
) (
  input  logic                        clk,
  input  logic                        rst,
  rgmii_inband_status_ctrl_if.slave   rx_if,
`ifdef RGMII_INBAND_FORCE_EN
  input  logic                        force_en,
  input  logic [1:0]                  force_speed,
`endif
  output link_state_e                 state_o
);

  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RESET_HOLD);

  link_state_e   state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          link_q, link_d;
  logic          dup_q, dup_d;
  logic [1:0]    spd_q, spd_d;
  logic          mac_rst_q, mac_rst_d;
  logic          sc_q, sc_d;

  logic          commit;
  link_status_t  cand;
  link_status_t  committed;
  logic          ignore_spd;
  logic          force_chg;

  assign committed.link = link_q;
  assign committed.spd  = spd_q;
  assign committed.dup  = dup_q;

`ifdef RGMII_INBAND_FORCE_EN
  assign ignore_spd = force_en;
  // speed tracks force_speed one cycle late, so a mismatch marks a fresh change.
  assign force_chg  = force_en && (force_speed != spd_q);
`else
  assign ignore_spd = 1'b0;
  assign force_chg  = 1'b0;
`endif

  inband_status_debounce #(
    .STABLE_COUNT (STABLE_COUNT)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .rxd_i        (rx_if.gmii_rxd),
    .rx_dv_i      (rx_if.gmii_rx_dv),
    .rx_er_i      (rx_if.gmii_rx_er),
    .committed_i  (committed),
    .ignore_spd_i (ignore_spd),
    .commit_o     (commit),
    .cand_o       (cand)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    link_d  = link_q;
    dup_d   = dup_q;
    spd_d   = spd_q;
    sc_d    = commit || (force_chg && (state_q == ST_UP));

    if (commit) begin
      link_d = cand.link;
      dup_d  = cand.dup;
      // A link-down report carries no meaningful speed; keep the last one.
      if (cand.link) spd_d = cand.spd;
    end
`ifdef RGMII_INBAND_FORCE_EN
    if (force_en) spd_d = force_speed;
`endif

    case (state_q)
      ST_DOWN: begin
        if (commit && cand.link) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (commit) begin
          if (cand.link) begin
            hold_d = HOLD_LOAD;
          end else begin
            state_d = ST_DOWN;
            hold_d  = '0;
          end
        end else begin
          hold_d = hold_q - 1'b1;
          if (hold_q == HW'(1)) state_d = ST_UP;
        end
      end
      ST_UP: begin
        if (commit) begin
          if (cand.link) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_LOAD;
          end else begin
            state_d = ST_DOWN;
          end
        end else if (force_chg) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      default: begin
        state_d = ST_DOWN;
        hold_d  = '0;
      end
    endcase

    mac_rst_d = (state_d != ST_UP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DOWN;
      hold_q    <= '0;
      link_q    <= 1'b0;
      dup_q     <= 1'b0;
      spd_q     <= DEFAULT_SPEED;
      mac_rst_q <= 1'b1;
      sc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      link_q    <= link_d;
      dup_q     <= dup_d;
      spd_q     <= spd_d;
      mac_rst_q <= mac_rst_d;
      sc_q      <= sc_d;
    end
  end

  assign rx_if.speed         = spd_q;
  assign rx_if.link_up       = link_q;
  assign rx_if.full_duplex   = dup_q;
  assign rx_if.mac_rst       = mac_rst_q;
  assign rx_if.status_change = sc_q;
  assign state_o             = state_q;

endmodule

// File: tb/tb_rgmii_inband_status_ctrl.sv
// Bench for rgmii_inband_status_ctrl: two instances (hold 8 and hold 24) on one
// receive bus, checked every cycle against a run-length status model plus literals.
`timescale 1ns/1ps
module tb_rgmii_inband_status_ctrl;
  import rgmii_inband_status_ctrl_pkg::*;

  localparam int SC   = 16;
  localparam int RH_A = 8;
  localparam int RH_B = 24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rgmii_inband_status_ctrl_if if_a ();
  rgmii_inband_status_ctrl_if if_b ();
  link_state_e st_a, st_b;

  assign if_b.gmii_rxd   = if_a.gmii_rxd;
  assign if_b.gmii_rx_dv = if_a.gmii_rx_dv;
  assign if_b.gmii_rx_er = if_a.gmii_rx_er;

  rgmii_inband_status_ctrl #(
    .STABLE_COUNT (SC), .RESET_HOLD (RH_A), .DEFAULT_SPEED (SPEED_1G)
  ) dut_a (
    .clk (clk), .rst (rst), .rx_if (if_a.slave), .state_o (st_a)
  );

  rgmii_inband_status_ctrl #(
    .STABLE_COUNT (SC), .RESET_HOLD (RH_B), .DEFAULT_SPEED (SPEED_1G)
  ) dut_b (
    .clk (clk), .rst (rst), .rx_if (if_b.slave), .state_o (st_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Status nibble layout as on the wire: [0]=link, [2:1]=speed, [3]=duplex.
  // A status commits when its run of valid samples first reaches SC and it
  // differs from what is committed; mac_rst is held RH cycles past each link-up commit.
  logic [3:0] m_run_val [2];
  int         m_run_len [2];
  logic       m_link    [2];
  logic       m_dup     [2];
  logic [1:0] m_spd     [2];
  logic       m_sc      [2];
  int         m_release [2];
  int         m_cyc;

  function automatic int rh_of(input int i);
    return (i == 0) ? RH_A : RH_B;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [7:0] d;
    logic       ok;
    logic [3:0] v;
    int         len;
    if (rst) begin
      m_cyc <= 0;
      for (int i = 0; i < 2; i++) begin
        m_run_val[i] <= 4'h0;
        m_run_len[i] <= 0;
        m_link[i]    <= 1'b0;
        m_dup[i]     <= 1'b0;
        m_spd[i]     <= SPEED_1G;
        m_sc[i]      <= 1'b0;
        m_release[i] <= 0;
      end
    end else begin
      d  = if_a.gmii_rxd;
      ok = !if_a.gmii_rx_dv && !if_a.gmii_rx_er && (d[3:0] == d[7:4]) && (d[2:1] != 2'b11);
      m_cyc <= m_cyc + 1;
      for (int i = 0; i < 2; i++) begin
        v   = m_run_val[i];
        len = m_run_len[i];
        m_sc[i] <= 1'b0;
        if (ok) begin
          if (d[3:0] == v) len = len + 1;
          else begin
            v   = d[3:0];
            len = 1;
          end
          if (len == SC && v != {m_dup[i], m_spd[i], m_link[i]}) begin
            m_sc[i]   <= 1'b1;
            m_link[i] <= v[0];
            m_dup[i]  <= v[3];
            if (v[0]) begin
              m_spd[i]     <= v[2:1];
              m_release[i] <= m_cyc + 1 + rh_of(i);
            end
          end
        end
        m_run_val[i] <= v;
        m_run_len[i] <= len;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp_inst(input string nm, input int i, input logic lk, input logic [1:0] sp,
                          input logic dp, input logic mr, input logic sc, input link_state_e st);
    logic        exp_rst;
    link_state_e exp_st;
    exp_rst = !m_link[i] || (m_cyc < m_release[i]);
    exp_st  = !m_link[i] ? ST_DOWN : ((m_cyc < m_release[i]) ? ST_HOLD : ST_UP);
    check({nm, ".link_up"}, lk, m_link[i]);
    check({nm, ".speed"}, sp, m_spd[i]);
    check({nm, ".full_duplex"}, dp, m_dup[i]);
    check({nm, ".mac_rst"}, mr, exp_rst);
    check({nm, ".status_change"}, sc, m_sc[i]);
    check({nm, ".state"}, st, exp_st);
  endtask

  int sc_seen_a = 0;
  always @(negedge clk) begin
    if (!rst) begin
      cmp_inst("cyc_a", 0, if_a.link_up, if_a.speed, if_a.full_duplex, if_a.mac_rst,
               if_a.status_change, st_a);
      cmp_inst("cyc_b", 1, if_b.link_up, if_b.speed, if_b.full_duplex, if_b.mac_rst,
               if_b.status_change, st_b);
      if (if_a.status_change) sc_seen_a++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic [7:0] d, input logic dv, input logic er);
    if_a.gmii_rxd   = d;
    if_a.gmii_rx_dv = dv;
    if_a.gmii_rx_er = er;
    @(posedge clk);
    #1;
  endtask

  task automatic samples(input logic [7:0] d, input int n);
    repeat (n) cyc(d, 1'b0, 1'b0);
  endtask

  task automatic lit_a(input string nm, input logic lk, input logic [1:0] sp, input logic dp,
                       input logic mr, input logic sc, input link_state_e st);
    check({nm, ".a.link_up"}, if_a.link_up, lk);
    check({nm, ".a.speed"}, if_a.speed, sp);
    check({nm, ".a.full_duplex"}, if_a.full_duplex, dp);
    check({nm, ".a.mac_rst"}, if_a.mac_rst, mr);
    check({nm, ".a.status_change"}, if_a.status_change, sc);
    check({nm, ".a.state"}, st_a, st);
  endtask

  task automatic lit_b(input string nm, input logic lk, input logic [1:0] sp, input logic dp,
                       input logic mr, input logic sc, input link_state_e st);
    check({nm, ".b.link_up"}, if_b.link_up, lk);
    check({nm, ".b.speed"}, if_b.speed, sp);
    check({nm, ".b.full_duplex"}, if_b.full_duplex, dp);
    check({nm, ".b.mac_rst"}, if_b.mac_rst, mr);
    check({nm, ".b.status_change"}, if_b.status_change, sc);
    check({nm, ".b.state"}, st_b, st);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int hi_cnt;
    int sc_before;

    if_a.gmii_rxd   = 8'h00;
    if_a.gmii_rx_dv = 1'b1;
    if_a.gmii_rx_er = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    lit_a("reset", 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, ST_DOWN);
    lit_b("reset", 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, ST_DOWN);
    rst = 1'b0;

    // Link up at 1G half duplex.
    samples(8'h55, 15);
    lit_a("up15", 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, ST_DOWN);
    samples(8'h55, 1);
    lit_a("up16", 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, ST_HOLD);
    check("model.link_a", m_link[0], 1'b1);
    check("model.hold_a", m_release[0] - m_cyc, RH_A);
    samples(8'h55, 7);
    lit_a("up_hold7", 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, ST_HOLD);
    samples(8'h55, 1);
    lit_a("up_hold8", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, ST_UP);
    lit_b("up_hold8", 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, ST_HOLD);

    // 55 interleaved with nibble-mismatch 53 leaves the committed status alone.
    sc_before = sc_seen_a;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) samples(8'h55, 5);
      else samples(8'h53, 5);
    end
    check("alt53.pulses", sc_seen_a - sc_before, 0);
    lit_a("alt53", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, ST_UP);

    // Two valid statuses that never stay stable long enough.
    sc_before = sc_seen_a;
    for (int k = 0; k < 11; k++) begin
      if (k % 2 == 0) samples(8'h55, 5);
      else samples(8'hBB, 5);
    end
    check("altBB.pulses", sc_seen_a - sc_before, 0);

    // Speed/duplex change from UP: 100M full duplex.
    samples(8'hBB, 15);
    lit_a("bb15", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, ST_UP);
    samples(8'hBB, 1);
    lit_a("bb16", 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, ST_HOLD);
    hi_cnt = 1;
    for (int j = 0; j < 30 && if_a.mac_rst; j++) begin
      samples(8'hBB, 1);
      if (if_a.mac_rst) hi_cnt++;
    end
    check("bb.mac_rst_cycles", hi_cnt, RH_A);

    // Frame, carrier extension and reserved speed code only pause the count.
    samples(8'h33, 10);
    for (int j = 0; j < 64; j++) cyc(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    lit_a("frame", 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, ST_UP);
    cyc(8'h33, 1'b0, 1'b1);
    cyc(8'h33, 1'b0, 1'b1);
    samples(8'h77, 2);
    samples(8'h33, 5);
    lit_a("post5", 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, ST_UP);
    samples(8'h33, 1);
    lit_a("post6", 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, ST_HOLD);

    // Link down while instance b is still holding.
    samples(8'h00, 15);
    lit_b("down15", 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, ST_HOLD);
    lit_a("down15", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, ST_UP);
    samples(8'h00, 1);
    lit_b("down16", 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, ST_DOWN);
    lit_a("down16", 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, ST_DOWN);
    check("model.link_b", m_link[1], 1'b0);

    // Duplex-only change with link down commits but stays DOWN.
    samples(8'h88, 16);
    lit_a("dn_dup", 1'b0, 2'b01, 1'b1, 1'b1, 1'b1, ST_DOWN);
    samples(8'h88, 3);

    // Asynchronous reset in the middle of HOLD.
    samples(8'hBB, 16);
    lit_a("pre_rst", 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, ST_HOLD);
    samples(8'hBB, 3);
    #2 rst = 1'b1;
    #1;
    lit_a("async_rst", 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, ST_DOWN);
    lit_b("async_rst", 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, ST_DOWN);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Debouncer restarts from scratch after reset.
    samples(8'hDD, 15);
    lit_a("rerun15", 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, ST_DOWN);
    samples(8'hDD, 1);
    lit_a("rerun16", 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, ST_HOLD);
    samples(8'hDD, 10);
    lit_a("rerun_up", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, ST_UP);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
